fixed_point_bit_reverse_deserializer: RTL
=========================================

Name: fixed_point_bit_reverse_deserializer

Overview:
- Input stage of the fixed-point FFT datapath.
- Accepts one complex fixed-point sample per handshake from a serial stream and collects N samples into a frame.
- Presents the whole frame in parallel, in bit-reversed order, to the butterfly/FFT stage downstream.
- Its send-side val/rdy connects directly to the FFT stage's recv-side val/rdy.

Parameters:
- n, 32: width of each real and imaginary component (fixed point, passed through unmodified).
- d, 16: fractional bits. No arithmetic is performed; carried for interface consistency only.
- N, 8: samples per frame. Must be a power of 2 and at least 2. Let L = $clog2(N).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- recv_val  input  1  upstream sample valid.
- recv_rdy  output  1  block can accept a sample.
- recv_r  input  n  real part of the incoming sample.
- recv_c  input  n  imaginary part of the incoming sample.
- send_val  output  1  full reordered frame is available.
- send_rdy  input  1  downstream accepts the frame.
- send_r  output  n x [N] (unpacked array)  real parts of the frame, lane k.
- send_c  output  n x [N] (unpacked array)  imaginary parts of the frame, lane k.

Behaviour:
- Two states: FILL = 0, SEND = 1. Sample counter cnt is L bits wide.
- Storage: N real and N imaginary registers. Outputs are driven directly from these registers, never combinationally from the inputs.
- Reset asserted, at any time including mid-frame:
  - state goes to FILL immediately and cnt goes to 0.
  - All storage registers go to 0, so all send_r and send_c lanes read 0.
  - send_val = 0.
  - recv_rdy = 0 while reset is high, and goes to 1 on the first cycle after reset deasserts.
- Handshake signals:
  - recv_rdy = (state == FILL) and not reset.
  - send_val = (state == SEND).
  - Both are pure functions of state and reset.
- FILL:
  - A transfer occurs on a cycle with recv_val && recv_rdy.
  - On a transfer: storage[bitrev_L(cnt)] <= {recv_r, recv_c} and cnt <= cnt + 1.
  - bitrev_L reverses the L low bits; for example, with N = 8, index 1 maps to 4 and index 3 maps to 6.
  - If cnt == N-1 on a transfer: state <= SEND and cnt wraps to 0.
  - recv_val low means no change. Gaps between samples are allowed.
- SEND:
  - recv_rdy = 0. Input data is ignored.
  - Outputs hold the frame stable for as long as send_rdy = 0, for any duration.
  - send_rdy = 1 means the frame is consumed and state <= FILL on that edge.
  - Storage is not cleared; it is overwritten by the next frame.
- Result: lane k carries the sample whose arrival index (0-based within the frame) is bitrev_L(k).
- Throughput: at most one frame every N+1 cycles, i.e. N fill cycles plus 1 send cycle. Receive is not overlapped with send.
- Latency: send_val rises on the cycle after the N-th accepted sample.
- No arithmetic is performed; values are passed bit-exact, including sign bits.

Test Plan:
- N=8 ordering: reset, then send samples i = 0..7 with recv_r = 0x100+i and recv_c = 0x200+i, with send_rdy = 1.
  - send_val is high for exactly 1 cycle, starting the cycle after the 8th transfer.
  - send_r lanes 0..7 = 0x100, 0x104, 0x102, 0x106, 0x101, 0x105, 0x103, 0x107. send_c follows the same order with 0x2xx.
- Backpressure: complete a frame, then hold send_rdy = 0 for 5 cycles.
  - send_val stays 1, the outputs stay bit-identical, and recv_rdy stays 0 even with recv_val = 1.
  - Raise send_rdy: the next cycle has send_val = 0 and recv_rdy = 1.
- Gapped input: toggle recv_val every other cycle with data 0xFFFF_FFF0+i (negative values).
  - The frame completes after the 8th valid, with values bit-exact and in bit-reversed order.
  - Cycles with recv_val = 0 do not advance cnt.
- Async reset mid-fill: after 3 transfers, pulse reset between clock edges.
  - send_val and all outputs go to 0 without waiting for a clock edge.
  - A subsequent full 8-sample frame (values 0x10..0x17) emerges correctly with no residue from the aborted frame.
- Back-to-back frames: keep send_rdy = 1 and recv_val = 1 continuously over two frames (values 0..7 then 8..15).
  - Frame 2 lanes = 8, 12, 10, 14, 9, 13, 11, 15.
  - Exactly one idle cycle (the SEND cycle) separates the last accept of frame 1 from the first accept of frame 2.
- N=2 instance: send samples 0xA, 0xB.
  - Lanes = 0xA, 0xB, since the bit reversal is the identity.
  - cnt wraps correctly and a second frame works.

Source files
------------

// File: rtl/fixed_point_bit_reverse_deserializer_if.sv
// Stream-in / frame-out handshake bundle for the FFT input deserializer.
// The slave modport is the deserializer's view; master is the driving environment.
interface fixed_point_bit_reverse_deserializer_if #(
  parameter int n = 32,
  parameter int N = 8
);
  logic         recv_val;
  logic         recv_rdy;
  logic [n-1:0] recv_r;
  logic [n-1:0] recv_c;
  logic         send_val;
  logic         send_rdy;
  logic [n-1:0] send_r [N];
  logic [n-1:0] send_c [N];

  modport master (
    output recv_val, recv_r, recv_c, send_rdy,
    input  recv_rdy, send_val, send_r, send_c
  );

  modport slave (
    input  recv_val, recv_r, recv_c, send_rdy,
    output recv_rdy, send_val, send_r, send_c
  );
endinterface

// File: rtl/fixed_point_bit_reverse_deserializer.sv
// Collects N serial complex samples and presents them as one parallel frame
// in bit-reversed lane order for the FFT butterfly stage.
module fixed_point_bit_reverse_deserializer #(
  parameter int n = 32,
  parameter int d = 16,
  parameter int N = 8
) (
  input  logic clk,
  input  logic reset,
  fixed_point_bit_reverse_deserializer_if.slave bus
);
  localparam int L = $clog2(N);
  localparam logic [L-1:0] CNT_LAST = L'(N - 1);

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("N must be a power of two and at least 2");
  end
  if (d < 0 || d > n) begin : g_bad_d
    $error("d must lie between 0 and n");
  end

  typedef enum logic {FILL = 1'b0, SEND = 1'b1} state_t;

  state_t       state;
  logic [L-1:0] cnt;
  logic [L-1:0] wr_idx;
  logic         xfer;

  always_comb begin
    wr_idx = '0;
    for (int b = 0; b < L; b++) begin
      wr_idx[b] = cnt[L-1-b];
    end
  end

  // Handshakes depend only on state and reset so rdy drops the instant reset rises.
  assign bus.recv_rdy = (state == FILL) && !reset;
  assign bus.send_val = (state == SEND);
  assign xfer         = bus.recv_val && (state == FILL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
      cnt   <= '0;
    end else if (state == FILL) begin
      if (xfer) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state <= SEND;
        end
      end
    end else begin
      if (bus.send_rdy) begin
        state <= FILL;
      end
    end
  end

  // Each lane captures the sample whose arrival index is the bit reversal of the lane number.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    localparam logic [L-1:0] IDX = L'(gi);
    logic [n-1:0] lane_r;
    logic [n-1:0] lane_c;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lane_r <= '0;
        lane_c <= '0;
      end else if (xfer && wr_idx == IDX) begin
        lane_r <= bus.recv_r;
        lane_c <= bus.recv_c;
      end
    end

    assign bus.send_r[gi] = lane_r;
    assign bus.send_c[gi] = lane_c;
  end
endmodule
